// File: rtl/isqrt_pkg.sv
// Shared types and helpers for the iterative integer square root.
// The root width is derived from the operand width and never set independently.
package isqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ROUND_FLOOR   = 0;
    localparam int ROUND_NEAREST = 1;

    function automatic int out_w_of(input int in_w);
        return in_w / 2;
    endfunction

    // Iteration counter holds OUT_W-1 down to 0; keep at least one bit.
    function automatic int cnt_w_of(input int out_w);
        return (out_w > 2) ? $clog2(out_w) : 1;
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit-by-digit square-root iteration: brings down two operand
// bits, trial-subtracts {root,01} and appends the resulting root bit.
module isqrt_step #(
    parameter int OUT_W = 16
) (
    input  logic [OUT_W:0]   rem,
    input  logic [OUT_W-1:0] root,
    input  logic [1:0]       bits,
    output logic [OUT_W:0]   rem_nxt,
    output logic [OUT_W-1:0] root_nxt
);

    logic [OUT_W+2:0] part;
    logic [OUT_W+2:0] trial;

    // The running remainder never exceeds twice the partial root, so the trial
    // is non-negative exactly when its two top bits are clear.
    always_comb begin
        part  = {rem, bits};
        trial = part - {1'b0, root, 2'b01};
        if (trial[OUT_W+2:OUT_W+1] == 2'b00) begin
            rem_nxt  = trial[OUT_W:0];
            root_nxt = {root[OUT_W-2:0], 1'b1};
        end else begin
            rem_nxt  = part[OUT_W:0];
            root_nxt = {root[OUT_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/isqrt_iter.sv
// Sequential integer square root, one root bit per clock, with valid/ready on
// both sides and optional round-to-nearest (saturating) on the root output.
module isqrt_iter
    import isqrt_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int ROUND = ROUND_FLOOR,
    localparam int OUT_W = out_w_of(IN_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  num,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] sqr,
    output logic [OUT_W:0]   rem,
    output state_t           dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready/valid here depend on the state register only.

    localparam int CNT_W = cnt_w_of(OUT_W);

    state_t             state_q, state_d;
    logic [IN_W-1:0]    op_q;
    logic [OUT_W-1:0]   root_q;
    logic [OUT_W:0]     rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [OUT_W-1:0]   sqr_q;
    logic [OUT_W-1:0]   root_step;
    logic [OUT_W:0]     rem_step;
    logic               round_up;
    logic [OUT_W-1:0]   sqr_final;

    isqrt_step #(.OUT_W(OUT_W)) u_step (
        .rem      (rem_q),
        .root     (root_q),
        .bits     (op_q[IN_W-1 -: 2]),
        .rem_nxt  (rem_step),
        .root_nxt (root_step)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)       state_d = BUSY;
            BUSY:    if (cnt_q == '0)    state_d = DONE;
            DONE:    if (out_ready)      state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Rounding looks at the final-iteration values; an all-ones root saturates.
    always_comb begin
        round_up  = (ROUND == ROUND_NEAREST) && (rem_step > {1'b0, root_step});
        sqr_final = (round_up && !(&root_step)) ? root_step + 1'b1 : root_step;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sqr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                op_q   <= num;
                root_q <= '0;
                rem_q  <= '0;
                cnt_q  <= CNT_W'(OUT_W - 1);
            end else if (state_q == BUSY) begin
                op_q   <= {op_q[IN_W-3:0], 2'b00};
                root_q <= root_step;
                rem_q  <= rem_step;
                if (cnt_q == '0) begin
                    sqr_q <= sqr_final;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sqr       = sqr_q;
    assign rem       = rem_q;
    assign dbg_state = state_q;

endmodule
